// File: rtl/lbll_key_loader.sv
// -----------------------------------------------------------------------------
// lbll_key_loader
//
// Receives the unlock key of a latch-based-locked netlist as a serial frame
// (NBITS key bits MSB first, followed by one even-parity bit), checks it and
// presents the committed parallel key to the locked core.
//
// The key is committed only after the whole frame has arrived and the parity
// check passes. A failing frame zeroes the key. A frame that is aborted or cut
// short by reset is never committed.
//
// Parameters
//   NBITS      key width in bits (>= 2), equal to the locked netlist key width
//
// Ports
//   clk        in   1      single clock for all state
//   rst_n      in   1      asynchronous, active-low reset
//   key_start  in   1      frame-start pulse; also aborts and restarts a frame
//   key_sen    in   1      serial enable; key_sdi is valid when 1
//   key_sdi    in   1      serial key data, MSB first, then the parity bit
//   lbll_key   out  NBITS  committed key to the locked core
//   key_valid  out  1      lbll_key holds a parity-checked key
//   key_err    out  1      last frame failed parity (sticky until key_start)
//   busy       out  1      frame in progress
// -----------------------------------------------------------------------------
module lbll_key_loader #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_sen,
  input  logic             key_sdi,
  output logic [NBITS-1:0] lbll_key,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);

  localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] shadow_nx;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_nx;
  logic [NBITS-1:0] key_nx;
  logic             valid_nx;
  logic             err_nx;

  // Registered state and outputs. busy is registered from the next state so
  // it is a clean flop output that tracks (state != IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      bit_cnt   <= '0;
      lbll_key  <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      bit_cnt   <= bit_cnt_nx;
      lbll_key  <= key_nx;
      key_valid <= valid_nx;
      key_err   <= err_nx;
      busy      <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx   = state;
    shadow_nx  = shadow;
    bit_cnt_nx = bit_cnt;
    key_nx     = lbll_key;
    valid_nx   = key_valid;
    err_nx     = key_err;

    if (key_start) begin
      // Start or restart a frame from any state; key_sen is ignored this
      // cycle and the current key stays in place until a frame fails.
      state_nx   = SHIFT;
      shadow_nx  = '0;
      bit_cnt_nx = '0;
      err_nx     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // key_sen is ignored outside a frame.
        end

        SHIFT: begin
          if (key_sen) begin
            shadow_nx = {shadow[NBITS-2:0], key_sdi};
            // The counter holds at its last value rather than wrapping.
            if (bit_cnt == LAST_BIT) begin
              state_nx = PARITY;
            end else begin
              bit_cnt_nx = bit_cnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (key_sen) begin
            if ((^{shadow, key_sdi}) == 1'b0) begin
              key_nx   = shadow;
              valid_nx = 1'b1;
              err_nx   = 1'b0;
            end else begin
              key_nx   = '0;
              valid_nx = 1'b0;
              err_nx   = 1'b1;
            end
            state_nx = IDLE;
          end
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbll_key_loader.sv
module tb_lbll_key_loader;

  localparam int unsigned NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_start = 1'b0;
  logic          key_sen = 1'b0;
  logic          key_sdi = 1'b0;
  logic [NB-1:0] lbll_key;
  logic          key_valid;
  logic          key_err;
  logic          busy;

  int checks = 0;
  int failures = 0;

  lbll_key_loader #(.NBITS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .key_sen   (key_sen),
    .key_sdi   (key_sdi),
    .lbll_key  (lbll_key),
    .key_valid (key_valid),
    .key_err   (key_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic          sen;
    logic          sdi;
    logic [NB-1:0] exp_key;
    logic          exp_valid;
    logic          exp_err;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sn, input logic sd,
                     input logic [NB-1:0] k, input logic v, input logic e,
                     input logic b);
    vec_t x;
    x.start = st; x.sen = sn; x.sdi = sd;
    x.exp_key = k; x.exp_valid = v; x.exp_err = e; x.exp_busy = b;
    vecs.push_back(x);
  endtask

  // Adds the 8 key bits of a frame with key_sen=1; outputs expected unchanged.
  task automatic add_bits(input logic [NB-1:0] kv, input logic [NB-1:0] hk,
                          input logic hv, input logic he);
    for (int i = NB - 1; i >= 0; i--) add(1'b0, 1'b1, kv[i], hk, hv, he, 1'b1);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [NB-1:0] k,
                           input logic v, input logic e, input logic b);
    check({tag, ".key"},   32'(lbll_key),  32'(k));
    check({tag, ".valid"}, 32'(key_valid), 32'(v));
    check({tag, ".err"},   32'(key_err),   32'(e));
    check({tag, ".busy"},  32'(busy),      32'(b));
  endtask

  // Drive one cycle at the falling edge, sample just after the rising edge.
  task automatic step(input logic st, input logic sn, input logic sd);
    @(negedge clk);
    key_start = st; key_sen = sn; key_sdi = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [NB-1:0] kv, input logic p);
    step(1'b1, 1'b0, 1'b0);
    for (int i = NB - 1; i >= 0; i--) step(1'b0, 1'b1, kv[i]);
    step(1'b0, 1'b1, p);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NB-1:0] kb2;
    logic [NB-1:0] k5a;
    logic [NB-1:0] k0f;
    logic [NB-1:0] ka5;
    kb2 = 8'hB2; k5a = 8'h5A; k0f = 8'h0F; ka5 = 8'hA5;

    // Reset state
    #12;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame B2 (p=0): busy high after start and each key bit
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add_bits(kb2, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
    // key_sen in IDLE ignored
    add(1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
    // Same key, bad parity: prior key cleared, error set
    add(1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b1);
    add_bits(kb2, 8'hB2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // Start with key_sen=1 (ignored) clears err; A5 with a stall in SHIFT
    // and a stall in PARITY
    add(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = NB - 1; i >= 0; i--) begin
      add(1'b0, 1'b1, ka5[i], 8'h00, 1'b0, 1'b0, 1'b1);
      if (i == 4) add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].sen, vecs[i].sdi);
      check_all($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_valid,
                vecs[i].exp_err, vecs[i].exp_busy);
    end

    // 5A with random stalls: no change until the parity bit is taken
    step(1'b1, 1'b0, 1'b0);
    for (int i = NB - 1; i >= 0; i--) begin
      int unsigned ns;
      ns = $urandom_range(0, 2);
      for (int s = 0; s < int'(ns); s++) begin
        step(1'b0, 1'b0, ~k5a[i]);
        check_all("stall", 8'hA5, 1'b1, 1'b0, 1'b1);
      end
      step(1'b0, 1'b1, k5a[i]);
      check_all("t3bit", 8'hA5, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    check_all("t3pstall", 8'hA5, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check_all("t3done", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Load B2, abort a frame after 4 bits, then send 0F: B2 held, valid stays
    load_key(kb2, 1'b0);
    check_all("t4load", 8'hB2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check_all("t4part", 8'hB2, 1'b1, 1'b0, 1'b1);
    end
    step(1'b1, 1'b1, 1'b1);
    check_all("t4abort", 8'hB2, 1'b1, 1'b0, 1'b1);
    for (int i = NB - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, k0f[i]);
      check_all("t4bit", 8'hB2, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0);
    check_all("t4done", 8'h0F, 1'b1, 1'b0, 1'b0);

    // Async reset mid-frame, then the rest of the frame without key_start
    step(1'b1, 1'b0, 1'b0);
    for (int i = NB - 1; i >= 4; i--) step(1'b0, 1'b1, kb2[i]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #0.5;
    check_all("t5rst", 8'h00, 1'b0, 1'b0, 1'b0);
    #0.5 rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, kb2[i]);
    step(1'b0, 1'b1, 1'b0);
    check_all("t5after", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (limit 200000)");
    $fatal(1, "timeout");
  end

endmodule
